// File: rtl/axi_burst_master_pkg.sv
// Shared types and helpers for the single-outstanding AXI4 burst initiator.
// Holds FSM encodings, fixed AXI field codes and the 4KB-boundary check.
package axi_burst_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    // True when a burst starting at addr_lo runs past the end of its 4KB page.
    function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                        input logic [7:0]  len,
                                        input logic [2:0]  size);
        logic [31:0] end_s;
        end_s = {20'd0, addr_lo} + (({24'd0, len} + 32'd1) << size);
        return end_s > 32'd4096;
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 initiator: one command becomes one INCR burst on AW/W/B or AR/R.
// Valids toward AXI address/response channels are registered; data beats pass through.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 16,
    parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                  ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  cmd_write,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  sts_valid,
    output logic                  sts_write,
    output logic [1:0]            sts_resp,
    output logic                  busy,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int                    SIZE       = $clog2(STRB_WIDTH);
    localparam logic [2:0]            SIZE_L     = 3'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << SIZE) - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic                  write_q, write_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic [1:0]            resp_acc_q, resp_acc_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  sts_valid_q, sts_valid_d;
    logic                  busy_q, busy_d;

    logic in_w_s, in_r_s, last_s, cmd_err_s;
    logic unused_ids_s;

    assign in_w_s    = (state_q == ST_W);
    assign in_r_s    = (state_q == ST_R);
    assign last_s    = (beat_cnt_q == {1'b0, len_q});
    assign cmd_err_s = (|(cmd_addr & ALIGN_MASK)) || crosses_4k(cmd_addr[11:0], cmd_len, SIZE_L);
    // Returning IDLE waits out the status cycle so the pulse never overlaps a new accept.
    assign cmd_ready = !rst && (state_q == ST_IDLE) && !sts_valid_q;

    assign unused_ids_s = ^{m_axi_bid, m_axi_rid};

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = SIZE_L;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_DEFAULT;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = SIZE_L;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE_DEFAULT;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_bready  = bready_q;

    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = wr_strb;
    assign m_axi_wvalid = in_w_s && wr_valid;
    assign m_axi_wlast  = in_w_s && last_s;
    assign wr_ready     = in_w_s && m_axi_wready;

    assign rd_data      = m_axi_rdata;
    assign rd_valid     = in_r_s && m_axi_rvalid;
    assign rd_last      = in_r_s && m_axi_rlast;
    assign m_axi_rready = in_r_s && rd_ready;

    assign sts_valid = sts_valid_q;
    assign sts_write = write_q;
    assign sts_resp  = resp_acc_q;
    assign busy      = busy_q;

    // Next-state and next-output computation for the burst FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        write_d     = write_q;
        beat_cnt_d  = beat_cnt_q;
        resp_acc_d  = resp_acc_q;
        awvalid_d   = awvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        sts_valid_d = 1'b0;
        busy_d      = sts_valid_q ? 1'b0 : busy_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    write_d    = cmd_write;
                    beat_cnt_d = 9'd0;
                    busy_d     = 1'b1;
                    resp_acc_d = cmd_err_s ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    if (cmd_err_s) begin
                        state_d = ST_ERR;
                    end else if (cmd_write) begin
                        state_d   = ST_AW;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = ST_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                if (m_axi_wvalid && m_axi_wready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (last_s) begin
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end
                end
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    resp_acc_d  = resp_max(resp_acc_q, m_axi_bresp);
                    sts_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (m_axi_rvalid && rd_ready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    resp_acc_d = resp_max(resp_acc_q, m_axi_rresp);
                    // A short or overlong burst is flagged, but only rlast terminates it.
                    if (m_axi_rlast != last_s) begin
                        resp_acc_d = AXI_RESP_SLVERR;
                    end
                    if (m_axi_rlast) begin
                        sts_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                sts_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= 8'd0;
            write_q     <= 1'b0;
            beat_cnt_q  <= 9'd0;
            resp_acc_q  <= AXI_RESP_OKAY;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            sts_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            write_q     <= write_d;
            beat_cnt_q  <= beat_cnt_d;
            resp_acc_q  <= resp_acc_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            sts_valid_q <= sts_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule
